// File: rtl/jimmy.sv
// jimmy: 8-bit accumulator-less microcontroller with four registers, four I/O ports and a fetch/operand FSM
module jimmy (
  input  logic       jimmy_clk,
  input  logic       reset,
  output logic [7:0] inst_address_bus,
  input  logic [7:0] inst_data_bus,
  input  logic [7:0] in_port_0,
  input  logic [7:0] in_port_1,
  input  logic [7:0] in_port_2,
  input  logic [7:0] in_port_3,
  output logic [7:0] out_port_0,
  output logic [7:0] out_port_1,
  output logic [7:0] out_port_2,
  output logic [7:0] out_port_3,
  output logic [3:0] out_strobe
);
  typedef enum logic {FETCH, OPERAND} state_t;
  state_t     state;
  logic [7:0] pc, ir, pc_inc, ins, a, b;
  logic [7:0] r [4];
  logic [7:0] out_q [4];
  logic [7:0] in_p [4];
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [8:0] alu;
  logic       z, c, wr_alu, upd_flags, taken;
  assign inst_address_bus = pc;
  assign in_p = '{in_port_0, in_port_1, in_port_2, in_port_3};
  assign out_port_0 = out_q[0];
  assign out_port_1 = out_q[1];
  assign out_port_2 = out_q[2];
  assign out_port_3 = out_q[3];
  assign ins    = state == OPERAND ? ir : inst_data_bus;
  assign op     = ins[7:4];
  assign rd     = ins[3:2];
  assign rs     = ins[1:0];
  assign a      = r[rd];
  assign b      = r[rs];
  assign pc_inc = pc + 8'd1;
  // bit 8 of the ALU result is the next carry/borrow flag
  always_comb begin
    alu = op == 4'h3 ? {1'b0, a} + {1'b0, b} :
          op == 4'h4 || op == 4'hE ? {1'b0, a} - {1'b0, b} :
          op == 4'h5 ? {1'b0, a & b} :
          op == 4'h6 ? {1'b0, a | b} :
          op == 4'h7 ? {1'b0, a ^ b} :
          op == 4'h8 ? {1'b0, a} + 9'd1 :
          op == 4'h9 ? {1'b0, a} - 9'd1 :
          op == 4'hD ? {a[0], 1'b0, a[7:1]} : {1'b0, a};
    wr_alu    = (op >= 4'h3 && op <= 4'h9) || op == 4'hD;
    upd_flags = wr_alu || op == 4'hE;
    taken     = rd == 2'd0 || (rd == 2'd1 && z) || (rd == 2'd2 && !z) || (rd == 2'd3 && c);
  end
  always_ff @(posedge jimmy_clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      ir         <= '0;
      z          <= 1'b0;
      c          <= 1'b0;
      r          <= '{default: '0};
      out_q      <= '{default: '0};
      out_strobe <= '0;
    end else begin
      out_strobe <= '0;
      if (state == OPERAND) begin
        state <= FETCH;
        if (op == 4'h1) begin
          r[rd] <= inst_data_bus;
          pc    <= pc_inc;
        end else
          pc <= taken ? inst_data_bus : pc_inc;
      end else if (op == 4'h1 || op == 4'hC) begin
        ir    <= inst_data_bus;
        pc    <= pc_inc;
        state <= OPERAND;
      end else if (op != 4'hF) begin
        pc <= pc_inc;
        if (wr_alu) r[rd] <= alu[7:0];
        if (upd_flags) begin
          z <= alu[7:0] == 8'd0;
          c <= alu[8];
        end
        if (op == 4'h2) r[rd] <= b;
        if (op == 4'hA) r[rd] <= in_p[rs];
        if (op == 4'hB) begin
          out_q[rs]  <= a;
          out_strobe <= 4'b0001 << rs;
        end
      end
    end
  end
endmodule

// File: tb/tb_jimmy.sv
// tb_jimmy: table-driven ALU/flag vectors, directed corner sequences and random programs vs an instruction-level model
module tb_jimmy;
  logic       jimmy_clk, reset;
  logic [7:0] inst_address_bus, inst_data_bus;
  logic [7:0] in_p [4];
  logic [7:0] out_port_0, out_port_1, out_port_2, out_port_3;
  logic [3:0] out_strobe;
  logic [7:0] mem [256];
  int n_vec, n_err;

  jimmy dut (
    .jimmy_clk(jimmy_clk), .reset(reset),
    .inst_address_bus(inst_address_bus), .inst_data_bus(inst_data_bus),
    .in_port_0(in_p[0]), .in_port_1(in_p[1]), .in_port_2(in_p[2]), .in_port_3(in_p[3]),
    .out_port_0(out_port_0), .out_port_1(out_port_1), .out_port_2(out_port_2), .out_port_3(out_port_3),
    .out_strobe(out_strobe)
  );

  assign inst_data_bus = mem[inst_address_bus];

  initial jimmy_clk = 1'b0;
  always #5 jimmy_clk = ~jimmy_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge jimmy_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  function automatic logic [31:0] ports();
    return {out_port_3, out_port_2, out_port_1, out_port_0};
  endfunction

  // instruction-level reference model
  logic [7:0] m_pc, m_r [4], m_out [4];
  logic [3:0] m_strobe;
  logic       m_z, m_c;

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_c = 0; m_strobe = 0;
    for (int i = 0; i < 4; i++) begin
      m_r[i] = 0;
      m_out[i] = 0;
    end
  endtask

  task automatic model_step(output int cyc);
    logic [7:0] ins, nx, opd, a, b, res;
    logic [1:0] d, s;
    int sum;
    bit flags, wr, tk;
    ins = mem[m_pc];
    nx = m_pc + 8'd1;
    opd = mem[nx];
    d = ins[3:2];
    s = ins[1:0];
    a = m_r[d];
    b = m_r[s];
    m_strobe = 0;
    cyc = 1;
    flags = 0;
    wr = 0;
    res = a;
    case (ins[7:4])
      4'h1: begin res = opd; wr = 1; cyc = 2; end
      4'h2: begin res = b; wr = 1; end
      4'h3: begin sum = int'(a) + int'(b); m_c = sum > 255; res = a + b; wr = 1; flags = 1; end
      4'h4: begin m_c = a < b; res = a - b; wr = 1; flags = 1; end
      4'h5: begin m_c = 0; res = a & b; wr = 1; flags = 1; end
      4'h6: begin m_c = 0; res = a | b; wr = 1; flags = 1; end
      4'h7: begin m_c = 0; res = a ^ b; wr = 1; flags = 1; end
      4'h8: begin m_c = a == 8'hFF; res = a + 8'd1; wr = 1; flags = 1; end
      4'h9: begin m_c = a == 8'h00; res = a - 8'd1; wr = 1; flags = 1; end
      4'hA: begin res = in_p[s]; wr = 1; end
      4'hB: begin m_out[s] = a; m_strobe[s] = 1'b1; end
      4'hC: cyc = 2;
      4'hD: begin m_c = a[0]; res = a >> 1; wr = 1; flags = 1; end
      4'hE: begin m_c = a < b; res = a - b; flags = 1; end
      default: ;
    endcase
    if (flags) m_z = res == 0;
    if (wr) m_r[d] = res;
    tk = d == 0 || (d == 1 && m_z) || (d == 2 && !m_z) || (d == 3 && m_c);
    if (ins[7:4] == 4'hC) m_pc = tk ? opd : m_pc + 8'd2;
    else if (ins[7:4] == 4'h1) m_pc = m_pc + 8'd2;
    else if (ins[7:4] != 4'hF) m_pc = m_pc + 8'd1;
  endtask

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a, b, res;
    logic c, z;
  } vec_t;
  vec_t vt[$];

  // runs op R0,R1 then reports R0 on port 0 and {C,Z} on port 1 via conditional jumps
  task automatic load_flag_prog(input vec_t v);
    logic [7:0] p [22];
    p = '{8'h10, v.a, 8'h14, v.b, {v.op, 4'h1}, 8'hB0, 8'h18, 8'h00, 8'hCC, 8'h0C, 8'hC0,
          8'h0E, 8'h18, 8'h02, 8'hC4, 8'h12, 8'hC0, 8'h14, 8'h88, 8'h00, 8'hB9, 8'hF0};
    fill(8'hF0);
    for (int i = 0; i < 22; i++) mem[i] = p[i];
  endtask

  task automatic run_to(input logic [7:0] addr, input int budget, input string nm);
    int k;
    k = 0;
    while (inst_address_bus !== addr && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) chk({nm, "_timeout"}, 32'(inst_address_bus), 32'(addr));
  endtask

  initial begin
    logic [7:0] q [$];
    int cyc;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) in_p[i] = 0;
    fill(8'hF0);
    do_reset();
    chk("reset_pc", 32'(inst_address_bus), 0);
    chk("reset_ports", ports(), 0);
    chk("reset_strobe", 32'(out_strobe), 0);

    vt.push_back('{4'h3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1});
    vt.push_back('{4'h3, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0});
    vt.push_back('{4'h4, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0});
    vt.push_back('{4'h4, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1});
    vt.push_back('{4'h5, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1});
    vt.push_back('{4'h6, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0});
    vt.push_back('{4'h7, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0});
    vt.push_back('{4'h8, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1});
    vt.push_back('{4'h8, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0});
    vt.push_back('{4'h9, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0});
    vt.push_back('{4'h9, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1});
    vt.push_back('{4'hD, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0});
    vt.push_back('{4'hD, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1});
    vt.push_back('{4'hE, 8'h03, 8'h05, 8'h03, 1'b1, 1'b0});
    vt.push_back('{4'hE, 8'h09, 8'h09, 8'h09, 1'b0, 1'b1});
    foreach (vt[i]) begin
      load_flag_prog(vt[i]);
      do_reset();
      run_to(8'h15, 80, "alu");
      chk($sformatf("alu%0d_res", i), 32'(out_port_0), 32'(vt[i].res));
      chk($sformatf("alu%0d_flags", i), 32'(out_port_1), {30'd0, vt[i].c, vt[i].z});
    end

    // LDI R1,5; OUT R1,p0 -> strobe pulse exactly one cycle
    fill(8'hF0);
    mem[0] = 8'h14; mem[1] = 8'h05; mem[2] = 8'hB4;
    do_reset();
    tick(2);
    chk("ldi_out_pre_strobe", 32'(out_strobe), 0);
    tick();
    chk("ldi_out_port0", 32'(out_port_0), 8'h05);
    chk("ldi_out_strobe", 32'(out_strobe), 4'b0001);
    tick();
    chk("ldi_out_strobe_drop", 32'(out_strobe), 0);

    // IN R2,p1; OUT R2,p3
    fill(8'hF0);
    mem[0] = 8'hA9; mem[1] = 8'hBB;
    in_p[1] = 8'h3C;
    do_reset();
    tick(2);
    chk("in_out_port3", 32'(out_port_3), 8'h3C);
    chk("in_out_strobe", 32'(out_strobe), 4'b1000);

    // countdown loop with JNZ
    fill(8'hF0);
    mem[0] = 8'h10; mem[1] = 8'h03; mem[2] = 8'h90; mem[3] = 8'hB0; mem[4] = 8'hC8; mem[5] = 8'h02;
    mem[6] = 8'h14; mem[7] = 8'hAA; mem[8] = 8'hB5;
    do_reset();
    cyc = 0;
    while (inst_address_bus !== 8'h09 && cyc < 100) begin
      tick();
      cyc++;
      if (out_strobe[0]) q.push_back(out_port_0);
    end
    chk("loop_count", 32'(q.size()), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("loop_val%0d", i), i < q.size() ? 32'(q[i]) : 32'hFFFF, 32'(2 - i));
    chk("loop_fallthrough", 32'(out_port_1), 8'hAA);

    // HALT at 0x05, then reset
    fill(8'h00);
    mem[0] = 8'h10; mem[1] = 8'h77; mem[2] = 8'hB1; mem[5] = 8'hF0;
    do_reset();
    tick(5);
    chk("halt_pc", 32'(inst_address_bus), 8'h05);
    tick(10);
    chk("halt_pc_frozen", 32'(inst_address_bus), 8'h05);
    chk("halt_ports", ports(), 32'h0000_7700);
    chk("halt_strobe", 32'(out_strobe), 0);
    do_reset();
    chk("halt_reset_pc", 32'(inst_address_bus), 0);
    chk("halt_reset_ports", ports(), 0);

    // reset during JMP operand, then FSM must be back in FETCH
    fill(8'hF0);
    mem[0] = 8'hC0; mem[1] = 8'h40;
    do_reset();
    tick();
    chk("jmp_operand_pc", 32'(inst_address_bus), 1);
    do_reset();
    chk("jmp_reset_pc", 32'(inst_address_bus), 0);
    tick();
    chk("jmp_refetch_pc", 32'(inst_address_bus), 1);
    tick();
    chk("jmp_taken_pc", 32'(inst_address_bus), 8'h40);

    // operand fetch wraps from 0xFF to 0x00
    fill(8'hF0);
    mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'hC0; mem[8'hC0] = 8'hF0;
    do_reset();
    tick(2);
    chk("wrap_at_ff", 32'(inst_address_bus), 8'hFF);
    tick();
    chk("wrap_operand", 32'(inst_address_bus), 8'h00);
    tick();
    chk("wrap_target", 32'(inst_address_bus), 8'hC0);

    // random programs against the model
    for (int prog = 0; prog < 20; prog++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom);
        if (mem[i][7:4] == 4'hF && $urandom_range(7) != 0) mem[i][7:4] = 4'h3;
      end
      do_reset();
      model_reset();
      for (int s = 0; s < 150; s++) begin
        for (int i = 0; i < 4; i++) in_p[i] = 8'($urandom);
        model_step(cyc);
        tick(cyc);
        chk("rnd_pc", 32'(inst_address_bus), 32'(m_pc));
        chk("rnd_ports", ports(), {m_out[3], m_out[2], m_out[1], m_out[0]});
        chk("rnd_strobe", 32'(out_strobe), 32'(m_strobe));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jimmy.md
JIMMY -- requirements
Module: jimmy

Interface
REQ-001 jimmy_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising jimmy_clk.
REQ-003 inst_address_bus  out  8  program address; equals PC combinationally.
REQ-004 inst_data_bus  in  8  program byte at inst_address_bus; valid in the same cycle (combinational external memory).
REQ-005 in_port_0..in_port_3  in  8 each  general input ports, sampled by IN.
REQ-006 out_port_0..out_port_3  out  8 each  registered output ports, written by OUT, hold value until next write.
REQ-007 out_strobe  out  4  bit p pulses high one cycle when out_port_p is written.

Function
REQ-008 State: R0-R3 (8-bit), PC (8-bit), flags Z and C, IR (8-bit), FSM {FETCH, OPERAND}.
REQ-009 Instruction byte: [7:4] opcode, [3:2] rd (or condition), [1:0] rs (or port p).
REQ-010 Single-byte op in FETCH: decode inst_data_bus, execute at edge, PC <= PC+1, stay FETCH (1 cycle).
REQ-011 Two-byte op (LDI, Jcc) in FETCH: IR <= byte, PC <= PC+1, go OPERAND; in OPERAND: operand = inst_data_bus, execute, go FETCH (2 cycles).
REQ-012 0x0 NOP; 0x1 LDI rd,imm: rd <= imm, PC+1, flags unchanged.
REQ-013 0x2 MOV rd,rs; flags unchanged.
REQ-014 0x3 ADD rd<=rd+rs, C=carry out; 0x4 SUB rd<=rd-rs, C=borrow (rd<rs).
REQ-015 0x5 AND, 0x6 OR, 0x7 XOR: rd <= rd op rs, C <= 0.
REQ-016 0x8 INC rd, C=1 on 0xFF->0x00; 0x9 DEC rd, C=1 on 0x00->0xFF.
REQ-017 0xA IN rd,p: rd <= in_port_p; flags unchanged.
REQ-018 0xB OUT rd,p: out_port_p <= rd and out_strobe[p] <= 1 for the following cycle only; other strobe bits 0.
REQ-019 0xC Jcc addr, cond in [3:2]: 00 always, 01 Z=1, 10 Z=0, 11 C=1; taken: PC <= operand; not taken: PC <= PC+1.
REQ-020 0xD SHR rd: rd <= {0,rd[7:1]}, C <= old rd[0].
REQ-021 0xE CMP rd,rs: flags as SUB, rd unchanged.
REQ-022 0xF HALT: PC, registers, ports frozen; only reset exits.
REQ-023 Z <= (result==0) for ops 0x3-0x9, 0xD, 0xE; all other ops leave Z, C unchanged.
REQ-024 All arithmetic modulo 256; PC wraps 0xFF->0x00, including operand fetch at 0xFF.
REQ-025 rd==rs permitted (e.g. XOR R1,R1 clears R1, Z=1).
REQ-026 out_strobe is 0 in every cycle not immediately following an OUT execution; back-to-back OUTs give consecutive pulses.

Reset
REQ-027 While reset=1 at an edge: PC=0x00, R0-R3=0, Z=C=0, IR=0, FSM=FETCH, out_port_0..3=0x00, out_strobe=0.
REQ-028 Reset overrides any in-progress instruction, including OPERAND state and HALT.
REQ-029 After reset deasserts, first fetch is from address 0x00 on the next edge.

Verification
REQ-030 Reset, program 0x14 0x05 (LDI R1,5), 0xB4 (OUT R1,p0) -> after 3 edges out_port_0=0x05, out_strobe=0001 for exactly one cycle.
REQ-031 LDI R0,0xFF; LDI R1,0x01; ADD R0,R1; OUT R0,p2 -> out_port_2=0x00, Z=1, C=1.
REQ-032 in_port_1=0x3C; IN R2,p1; OUT R2,p3 -> out_port_3=0x3C, out_strobe=1000 pulse.
REQ-033 Countdown loop: LDI R0,3; DEC R0; OUT R0,p0; JNZ back -> out_port_0 sequence 2,1,0, then falls through.
REQ-034 HALT at 0x05 -> inst_address_bus stays 0x05 indefinitely; reset asserted -> 0x00, all outputs 0.
REQ-035 Reset asserted during OPERAND of a JMP -> PC=0x00, jump not taken, FSM=FETCH.
